ble_cmd_auth: RTL and testbench

Receives serial command bytes from the BLE module on the `RX` pin, which the Segway bench drives from its UART transmitter at 19200 baud. Authorizes Segway power-up from those bytes. Sits directly downstream of the BLE/UART link, inside the Segway top level. Its `pwr_up` output gates the balance controller and steering logic.

---
 rtl/seg_cmd_pkg.sv | 30 +++
 rtl/uart_rx.sv | 168 ++++++++++++++++
 rtl/ble_cmd_auth.sv | 89 ++++++++
 tb/tb_ble_cmd_auth.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_cmd_pkg.sv
// -----------------------------------------------------------------------------
// seg_cmd_pkg
// Shared types and constants for the Segway BLE command receiver and the
// power-up authorization logic.
//   rx_state_t       : UART receiver FSM states
//   auth_state_t     : power authorization FSM states
//   CMD_GO / CMD_STOP: ASCII command bytes from the BLE module
//   BAUD_DIV_DEFAULT : clocks per bit (50 MHz / 19200)
// -----------------------------------------------------------------------------
package seg_cmd_pkg;

   localparam int unsigned BAUD_DIV_DEFAULT = 2604;

   localparam logic [7:0] CMD_GO   = 8'h67;  // 'g'
   localparam logic [7:0] CMD_STOP = 8'h73;  // 's'

   typedef enum logic [1:0] {
      RxIdle,
      RxStart,
      RxData,
      RxStop
   } rx_state_t;

   typedef enum logic [1:0] {
      AuthOff,
      AuthPwr1,
      AuthPwr2
   } auth_state_t;

endpackage

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver, LSB first. The asynchronous serial input passes through a
// 2-flop synchronizer; a start bit is only recognised on a high-to-low
// transition of the synchronized line, so a line stuck low never re-triggers.
// Optional stop-bit check: define STOP_BIT_CHK_EN to enable frm_err.
// Ports:
//   clk     in   system clock
//   rst_n   in   asynchronous active-low reset
//   rx      in   serial line, idles high, asynchronous to clk
//   rx_data out  last accepted byte
//   rdy     out  one-cycle pulse, rx_data updated
//   frm_err out  one-cycle pulse on a low stop bit (0 unless STOP_BIT_CHK_EN)
// -----------------------------------------------------------------------------
module uart_rx
   import seg_cmd_pkg::*;
#(
   parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rdy,
   output logic       frm_err
);

   localparam int unsigned CntW = $clog2(BAUD_DIV);

   // Counter expires when it reads zero, so a load of N-1 spans N clocks.
   localparam logic [CntW-1:0] FullLd = CntW'(BAUD_DIV - 1);
   // Edge detection costs one clock after the synchronized fall, so load two
   // short: the start sample lands BAUD_DIV/2 clocks after the synchronized edge.
   localparam logic [CntW-1:0] HalfLd = CntW'(BAUD_DIV / 2 - 2);

   // Synchronizer and edge-detect history, all reset to the idle level.
   logic rx_meta_q, rx_sync_q, rx_prev_q;

   rx_state_t       state_d, state_q;
   logic [CntW-1:0] baud_cnt_d, baud_cnt_q;
   logic [2:0]      bit_cnt_d, bit_cnt_q;
   logic [7:0]      shift_d, shift_q;
   logic [7:0]      rx_data_d, rx_data_q;
   logic            rdy_d, rdy_q;
   logic            expire;
`ifdef STOP_BIT_CHK_EN
   logic            frm_err_d, frm_err_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
      end
   end

   assign expire = (baud_cnt_q == '0);

   always_comb begin
      state_d    = state_q;
      baud_cnt_d = baud_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      rx_data_d  = rx_data_q;
      rdy_d      = 1'b0;
`ifdef STOP_BIT_CHK_EN
      frm_err_d  = 1'b0;
`endif

      unique case (state_q)
         RxIdle: begin
            if (!rx_sync_q && rx_prev_q) begin
               state_d    = RxStart;
               baud_cnt_d = HalfLd;
            end
         end

         RxStart: begin
            if (expire) begin
               if (!rx_sync_q) begin
                  state_d    = RxData;
                  bit_cnt_d  = '0;
                  baud_cnt_d = FullLd;
               end else begin
                  // Line back high at mid-start: treat as a glitch.
                  state_d = RxIdle;
               end
            end else begin
               baud_cnt_d = baud_cnt_q - CntW'(1);
            end
         end

         RxData: begin
            if (expire) begin
               shift_d    = {rx_sync_q, shift_q[7:1]};
               bit_cnt_d  = bit_cnt_q + 3'd1;
               baud_cnt_d = FullLd;
               if (bit_cnt_q == 3'd7) begin
                  state_d = RxStop;
               end
            end else begin
               baud_cnt_d = baud_cnt_q - CntW'(1);
            end
         end

         RxStop: begin
            if (expire) begin
               state_d = RxIdle;
`ifdef STOP_BIT_CHK_EN
               if (rx_sync_q) begin
                  rx_data_d = shift_q;
                  rdy_d     = 1'b1;
               end else begin
                  frm_err_d = 1'b1;
               end
`else
               rx_data_d = shift_q;
               rdy_d     = 1'b1;
`endif
            end else begin
               baud_cnt_d = baud_cnt_q - CntW'(1);
            end
         end

         default: state_d = RxIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RxIdle;
         baud_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         rx_data_q  <= '0;
         rdy_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         rx_data_q  <= rx_data_d;
         rdy_q      <= rdy_d;
      end
   end

`ifdef STOP_BIT_CHK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frm_err_q <= 1'b0;
      end else begin
         frm_err_q <= frm_err_d;
      end
   end
   assign frm_err = frm_err_q;
`else
   assign frm_err = 1'b0;
`endif

   assign rx_data = rx_data_q;
   assign rdy     = rdy_q;

endmodule

// File: rtl/ble_cmd_auth.sv
// -----------------------------------------------------------------------------
// ble_cmd_auth
// Receives command bytes from the BLE module and decides whether the Segway
// may run. 'g' powers up; 's' powers down immediately if no rider is present,
// otherwise waits (PWR2) until the rider steps off or 'g' is received again.
// Optional stop-bit check: define STOP_BIT_CHK_EN to enable frm_err.
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   RX        in   serial line from BLE, idles high
//   rider_off in   no rider on the load cells
//   pwr_up    out  authorized to run (registered)
//   cmd       out  last received byte
//   cmd_rdy   out  one-cycle pulse, new cmd valid
//   frm_err   out  one-cycle pulse on a bad stop bit (0 unless STOP_BIT_CHK_EN)
// -----------------------------------------------------------------------------
module ble_cmd_auth
   import seg_cmd_pkg::*;
#(
   parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       RX,
   input  logic       rider_off,
   output logic       pwr_up,
   output logic [7:0] cmd,
   output logic       cmd_rdy,
   output logic       frm_err
);

   auth_state_t state_d, state_q;
   logic        pwr_up_d, pwr_up_q;
   logic        go_cmd, stop_cmd;

   uart_rx #(
      .BAUD_DIV(BAUD_DIV)
   ) u_uart_rx (
      .clk    (clk),
      .rst_n  (rst_n),
      .rx     (RX),
      .rx_data(cmd),
      .rdy    (cmd_rdy),
      .frm_err(frm_err)
   );

   assign go_cmd   = cmd_rdy && (cmd == CMD_GO);
   assign stop_cmd = cmd_rdy && (cmd == CMD_STOP);

   always_comb begin
      state_d = state_q;

      unique case (state_q)
         AuthOff: begin
            if (go_cmd) state_d = AuthPwr1;
         end

         AuthPwr1: begin
            if (stop_cmd) state_d = rider_off ? AuthOff : AuthPwr2;
         end

         AuthPwr2: begin
            // A fresh 'g' takes priority over the rider leaving.
            if (go_cmd) begin
               state_d = AuthPwr1;
            end else if (rider_off) begin
               state_d = AuthOff;
            end
         end

         default: state_d = AuthOff;
      endcase

      pwr_up_d = (state_d != AuthOff);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= AuthOff;
         pwr_up_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pwr_up_q <= pwr_up_d;
      end
   end

   assign pwr_up = pwr_up_q;

endmodule

// File: tb/tb_ble_cmd_auth.sv
`timescale 1ns / 1ps
module tb_ble_cmd_auth;

   localparam int B   = 16;             // reduced baud divider for simulation
   localparam int H   = B / 2;
   localparam int LAT = 2 + H + 9 * B;  // RX fall to cmd_rdy, in clocks

   logic       clk = 1'b0;
   logic       rst_n;
   logic       RX;
   logic       rider_off;
   logic       pwr_up;
   logic [7:0] cmd;
   logic       cmd_rdy;
   logic       frm_err;

   int  errors = 0;
   int  checks = 0;
   int  rdy_cnt = 0;
   int  err_cnt = 0;
   bit  abort = 1'b0;

   ble_cmd_auth #(
      .BAUD_DIV(B)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .RX       (RX),
      .rider_off(rider_off),
      .pwr_up   (pwr_up),
      .cmd      (cmd),
      .cmd_rdy  (cmd_rdy),
      .frm_err  (frm_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (cmd_rdy) rdy_cnt++;
      if (frm_err) err_cnt++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [7:0] data;
      logic       rider;
      int         exp_rdy;
      logic [7:0] exp_cmd;
      logic       exp_pwr;
   } vec_t;

   vec_t tbl[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive_bit(input logic v, input int n);
      if (abort) return;
      RX = v;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (abort) break;
      end
   endtask

   task automatic send_byte(input logic [7:0] d, input logic stop, input int stop_len);
      @(posedge clk);
      #1;
      drive_bit(1'b0, B);
      for (int k = 0; k < 8; k++) drive_bit(d[k], B);
      drive_bit(stop, stop_len);
      RX = 1'b1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      int  r0, e0, n;
      bit  ok;

      tbl[0] = '{8'h67, 1'b0, 1, 8'h67, 1'b1};  // OFF  -> PWR1
      tbl[1] = '{8'h41, 1'b0, 1, 8'h41, 1'b1};  // PWR1 ignores 'A'
      tbl[2] = '{8'h73, 1'b0, 1, 8'h73, 1'b1};  // PWR1 -> PWR2 (rider on)
      tbl[3] = '{8'h41, 1'b0, 1, 8'h41, 1'b1};  // PWR2 ignores 'A'
      tbl[4] = '{8'h67, 1'b0, 1, 8'h67, 1'b1};  // PWR2 -> PWR1
      tbl[5] = '{8'h73, 1'b1, 1, 8'h73, 1'b0};  // PWR1 -> OFF (rider off)
      tbl[6] = '{8'h41, 1'b0, 1, 8'h41, 1'b0};  // OFF ignores 'A'
      tbl[7] = '{8'h73, 1'b0, 1, 8'h73, 1'b0};  // OFF ignores 's'
      tbl[8] = '{8'h00, 1'b0, 1, 8'h00, 1'b0};  // OFF ignores 0x00

      RX        = 1'b1;
      rider_off = 1'b0;
      rst_n     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_pwr_up", pwr_up, 0);
      check("reset_cmd", cmd, 8'h00);
      check("reset_cmd_rdy", cmd_rdy, 0);
      check("reset_frm_err", frm_err, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Frame latency and one-cycle auth latency on the first 'g'.
      fork
         send_byte(8'h67, 1'b1, B);
      join_none
      wait (RX == 1'b0);
      ok = 1'b0;
      n  = 0;
      while (!ok && n < 400) begin
         @(negedge clk);
         n++;
         if (cmd_rdy) ok = 1'b1;
      end
      check("lat_seen", 32'(ok), 1);
      checks++;
      if (n - 1 < LAT - 1 || n - 1 > LAT + 1) begin
         errors++;
         $display("FAIL lat_window: got %0d clocks expected %0d +/-1", n - 1, LAT);
      end
      check("lat_cmd", cmd, 8'h67);
      check("lat_pwr_before", pwr_up, 0);
      @(negedge clk);
      check("lat_rdy_width", cmd_rdy, 0);
      check("lat_pwr_after", pwr_up, 1);
      repeat (B) @(negedge clk);
      do_reset();

      // Table of frames walking the auth FSM.
      for (int i = 0; i < 9; i++) begin
         rider_off = tbl[i].rider;
         r0 = rdy_cnt;
         e0 = err_cnt;
         send_byte(tbl[i].data, 1'b1, B);
         repeat (2) @(negedge clk);
         check($sformatf("vec%0d_rdy", i), rdy_cnt - r0, tbl[i].exp_rdy);
         check($sformatf("vec%0d_err", i), err_cnt - e0, 0);
         check($sformatf("vec%0d_cmd", i), cmd, tbl[i].exp_cmd);
         check($sformatf("vec%0d_pwr", i), pwr_up, tbl[i].exp_pwr);
      end
      rider_off = 1'b0;

      // PWR2 released by rider stepping off.
      send_byte(8'h67, 1'b1, B);
      send_byte(8'h73, 1'b1, B);
      repeat (2) @(negedge clk);
      check("pwr2_hold", pwr_up, 1);
      rider_off = 1'b1;
      @(negedge clk);
      check("pwr2_release", pwr_up, 0);
      rider_off = 1'b0;

      // Short low glitch is rejected, next frame still received.
      r0 = rdy_cnt;
      @(posedge clk);
      #1;
      RX = 1'b0;
      repeat (H - 4) @(posedge clk);
      #1;
      RX = 1'b1;
      repeat (12 * B) @(negedge clk);
      check("glitch_no_rdy", rdy_cnt - r0, 0);
      send_byte(8'h67, 1'b1, B);
      repeat (2) @(negedge clk);
      check("glitch_then_rdy", rdy_cnt - r0, 1);
      check("glitch_then_cmd", cmd, 8'h67);
      check("glitch_then_pwr", pwr_up, 1);

      // Line held low for several frame times: at most one frame, no re-trigger.
      r0 = rdy_cnt;
      e0 = err_cnt;
      @(posedge clk);
      #1;
      RX = 1'b0;
      repeat (60 * B) @(posedge clk);
      #1;
      RX = 1'b1;
      repeat (2 * B) @(negedge clk);
`ifdef STOP_BIT_CHK_EN
      check("low_rdy", rdy_cnt - r0, 0);
      check("low_err", err_cnt - e0, 1);
      check("low_cmd", cmd, 8'h67);
`else
      check("low_rdy", rdy_cnt - r0, 1);
      check("low_err", err_cnt - e0, 0);
      check("low_cmd", cmd, 8'h00);
`endif
      check("low_pwr", pwr_up, 1);
      rider_off = 1'b1;
      send_byte(8'h73, 1'b1, B);
      repeat (2) @(negedge clk);
      rider_off = 1'b0;
      check("low_then_stop_pwr", pwr_up, 0);
      check("low_then_stop_cmd", cmd, 8'h73);

      // 'g' with a low stop bit, from OFF.
      r0 = rdy_cnt;
      e0 = err_cnt;
      send_byte(8'h67, 1'b0, B);
      repeat (2) @(negedge clk);
`ifdef STOP_BIT_CHK_EN
      check("badstop_rdy", rdy_cnt - r0, 0);
      check("badstop_err", err_cnt - e0, 1);
      check("badstop_cmd", cmd, 8'h73);
      check("badstop_pwr", pwr_up, 0);
`else
      check("badstop_rdy", rdy_cnt - r0, 1);
      check("badstop_err", err_cnt - e0, 0);
      check("badstop_cmd", cmd, 8'h67);
      check("badstop_pwr", pwr_up, 1);
`endif
      do_reset();

      // Back-to-back frames: next start bit right after the stop sample.
      r0 = rdy_cnt;
      send_byte(8'h67, 1'b1, H + 2);
      send_byte(8'h41, 1'b1, B);
      repeat (2) @(negedge clk);
      check("b2b_rdy", rdy_cnt - r0, 2);
      check("b2b_cmd", cmd, 8'h41);
      check("b2b_pwr", pwr_up, 1);

      // Reset asserted during bit 4 of a frame.
      fork
         send_byte(8'h67, 1'b1, B);
      join_none
      wait (RX == 1'b0);
      repeat (2 + H + 4 * B) @(posedge clk);
      #1;
      abort = 1'b1;
      rst_n = 1'b0;
      #1;
      check("midrst_pwr", pwr_up, 0);
      check("midrst_cmd", cmd, 8'h00);
      check("midrst_rdy", cmd_rdy, 0);
      check("midrst_err", frm_err, 0);
      repeat (3) @(posedge clk);
      #1;
      RX    = 1'b1;
      abort = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      r0 = rdy_cnt;
      e0 = err_cnt;
      repeat (20 * B) @(negedge clk);
      check("midrst_after_rdy", rdy_cnt - r0, 0);
      check("midrst_after_err", err_cnt - e0, 0);
      check("midrst_after_pwr", pwr_up, 0);
      check("midrst_after_cmd", cmd, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
